// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares memory port A between the CPU and a debug master.
// The CPU has priority. A starvation counter forces a debug slot after
// STARVE_MAX refused cycles, and a lock mode hands the port to debug exclusively.
// Read data returns one cycle after the grant, only to the master that issued it.
// fsm_state (1 = locked) and starve_count expose internal state for observation.
//
// Handshake: a master holds req and its fields stable until it sees gnt in the
// same cycle. A granted read returns rvalid for exactly one cycle on the next
// cycle. A granted write commits at the rising edge that ends the grant cycle.
module mem_port_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              fsm_state,
  output logic [3:0]        starve_count
);

  typedef enum logic {
    S_SHARE = 1'b0,
    S_LOCK  = 1'b1
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  logic [3:0] starve;
  logic       cpu_rd_q;
  logic       dbg_rd_q;
  logic       starved;
  logic       share_dbg;

  // Debug wins a shared cycle when the CPU is idle or debug has waited long enough.
  assign starved   = (starve == STARVE_LIM);
  assign share_dbg = dbg_req & (~cpu_req | starved);

  // Grant decision; in the release cycle of a lock only shared-mode debug rules apply.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (rst) begin
      if (state == S_LOCK) begin
        dbg_gnt = dbg_lock ? dbg_req : share_dbg;
      end else begin
        dbg_gnt = share_dbg;
        cpu_gnt = cpu_req & ~share_dbg;
      end
    end
  end

  // Port mux: the granted master drives the port, otherwise it idles at zero.
  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 1'b0;
    if (dbg_gnt) begin
      mem_addr = dbg_addr;
      mem_din  = dbg_wdata;
      mem_we   = dbg_we;
    end else if (cpu_gnt) begin
      mem_addr = cpu_addr;
      mem_din  = cpu_wdata;
      mem_we   = cpu_we;
    end
  end

  assign cpu_stall    = cpu_req & ~cpu_gnt;
  assign cpu_rvalid   = cpu_rd_q;
  assign dbg_rvalid   = dbg_rd_q;
  assign cpu_rdata    = mem_dout;
  assign dbg_rdata    = mem_dout;
  assign fsm_state    = (state == S_LOCK);
  assign starve_count = starve;

  // Lock state machine, starvation counter and read-return owner flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_SHARE;
      starve   <= 4'd0;
      cpu_rd_q <= 1'b0;
      dbg_rd_q <= 1'b0;
    end else begin
      case (state)
        S_SHARE: if (dbg_gnt & dbg_lock) state <= S_LOCK;
        S_LOCK:  if (!dbg_lock) state <= S_SHARE;
        default: state <= S_SHARE;
      endcase
      if (dbg_gnt | ~dbg_req) begin
        starve <= 4'd0;
      end else if (!starved) begin
        starve <= starve + 4'd1;
      end
      cpu_rd_q <= cpu_gnt & ~cpu_we;
      dbg_rd_q <= dbg_gnt & ~dbg_we;
    end
  end

endmodule
